// File: rtl/axis_splitter_op_sequencer.sv
// Descriptor-driven sequencer for the multi-channel AXI-Stream splitter.
// Issues one start per operation and enforces watchdog timeout and abort handling.
module axis_splitter_op_sequencer #(
    parameter int PCKT_WIDTH     = 32,
    parameter int REP_WIDTH      = 16,
    parameter int TIMEOUT_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ABORT_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [PCKT_WIDTH-1:0] cmd_packet_size,
    input  logic [REP_WIDTH-1:0]  cmd_count,
    input  logic                  abort,
    output logic                  operation_start,
    output logic [PCKT_WIDTH-1:0] packet_size,
    output logic                  external_error,
    input  logic                  operation_busy,
    input  logic                  operation_complete,
    input  logic                  operation_error,
    output logic                  seq_busy,
    output logic                  done_pulse,
    output logic                  err_pulse,
    output logic [1:0]            err_code,
    output logic [REP_WIDTH-1:0]  ops_done
);
    localparam int ABORT_W = $clog2(ABORT_CYCLES + 1);
    localparam logic [ABORT_W-1:0]       ABORT_LAST = ABORT_W'(ABORT_CYCLES - 1);
    localparam logic [ABORT_W-1:0]       ABORT_ONE  = ABORT_W'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE     = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                       TO_EN      = (TIMEOUT_CYCLES != 0);
    // Without a limit the watchdog still must not wrap, so it parks at all-ones.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_CAP     = TO_EN ? TO_LIMIT : {TIMEOUT_WIDTH{1'b1}};
    localparam logic [REP_WIDTH-1:0]     REP_ONE    = REP_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_operation_start;
    logic [PCKT_WIDTH-1:0]    r_packet_size;
    logic                     r_external_error;
    logic                     r_seq_busy;
    logic                     r_done_pulse;
    logic                     r_err_pulse;
    logic [1:0]               r_err_code;
    logic [REP_WIDTH-1:0]     r_ops_done;
    logic [REP_WIDTH-1:0]     r_remaining;
    logic [REP_WIDTH-1:0]     r_cmd_count;
    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [ABORT_W-1:0]       r_abort_cnt;

    logic                     w_accept;
    logic                     w_bad_cmd;
    logic                     w_timeout;
    logic [TIMEOUT_WIDTH-1:0] w_wd_inc;
    logic [1:0]               w_err_code;
    logic                     w_done_evt;
    logic                     w_err_evt;
    logic                     w_complete_evt;
    logic                     w_unused;

    // The splitter's busy flag carries no information the sequencer acts on.
    assign w_unused  = operation_busy;
    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_bad_cmd = (cmd_count == {REP_WIDTH{1'b0}}) || (cmd_packet_size == {PCKT_WIDTH{1'b0}});
    assign w_wd_inc  = r_wd + WD_ONE;
    // The limit is detected on the increment so the ABORT entry lands TIMEOUT_CYCLES+1 after start.
    assign w_timeout = TO_EN && (w_wd_inc >= TO_LIMIT);

    // Next-state and event decode; RUN priority is abort > error > timeout > complete.
    always_comb begin
        w_next         = r_state;
        w_err_code     = r_err_code;
        w_done_evt     = 1'b0;
        w_err_evt      = 1'b0;
        w_complete_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_bad_cmd) begin
                    w_err_evt  = 1'b1;
                    w_err_code = 2'd3;
                end else if (w_accept) begin
                    w_next     = S_START;
                    w_err_code = 2'd0;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (abort) begin
                    w_next     = S_ABORT;
                    w_err_code = 2'd2;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next     = S_ABORT;
                    w_err_code = 2'd2;
                end else if (operation_error) begin
                    w_next     = S_IDLE;
                    w_err_evt  = 1'b1;
                    w_err_code = 2'd1;
                end else if (w_timeout) begin
                    w_next     = S_ABORT;
                    w_err_code = 2'd2;
                end else if (operation_complete) begin
                    w_complete_evt = 1'b1;
                    if (r_remaining == REP_ONE) begin
                        w_next     = S_IDLE;
                        w_done_evt = 1'b1;
                    end else begin
                        w_next = S_START;
                    end
                end else begin
                    w_next = S_RUN;
                end
            end
            S_ABORT: begin
                if (r_abort_cnt == ABORT_LAST) begin
                    w_next    = S_IDLE;
                    w_err_evt = 1'b1;
                end else begin
                    w_next = S_ABORT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, registered outputs, progress counters, watchdog and abort hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_operation_start <= 1'b0;
            r_packet_size     <= {PCKT_WIDTH{1'b0}};
            r_external_error  <= 1'b0;
            r_seq_busy        <= 1'b0;
            r_done_pulse      <= 1'b0;
            r_err_pulse       <= 1'b0;
            r_err_code        <= 2'd0;
            r_ops_done        <= {REP_WIDTH{1'b0}};
            r_remaining       <= {REP_WIDTH{1'b0}};
            r_cmd_count       <= {REP_WIDTH{1'b0}};
            r_wd              <= {TIMEOUT_WIDTH{1'b0}};
            r_abort_cnt       <= {ABORT_W{1'b0}};
        end else begin
            r_state           <= w_next;
            r_operation_start <= (w_next == S_START);
            r_external_error  <= (w_next == S_ABORT);
            r_seq_busy        <= (w_next != S_IDLE) || w_accept;
            r_done_pulse      <= w_done_evt;
            r_err_pulse       <= w_err_evt;
            r_err_code        <= w_err_code;
            if (w_accept) begin
                r_packet_size <= cmd_packet_size;
                r_remaining   <= cmd_count;
                r_cmd_count   <= cmd_count;
                r_ops_done    <= {REP_WIDTH{1'b0}};
            end else if (w_complete_evt) begin
                if (r_ops_done != r_cmd_count) begin
                    r_ops_done <= r_ops_done + REP_ONE;
                end
                if (!w_done_evt) begin
                    r_remaining <= r_remaining - REP_ONE;
                end
            end
            if (r_state == S_START) begin
                r_wd <= {TIMEOUT_WIDTH{1'b0}};
            end else if ((r_state == S_RUN) && (r_wd != WD_CAP)) begin
                r_wd <= w_wd_inc;
            end
            r_abort_cnt <= (r_state == S_ABORT) ? (r_abort_cnt + ABORT_ONE) : {ABORT_W{1'b0}};
        end
    end

    assign operation_start = r_operation_start;
    assign packet_size     = r_packet_size;
    assign external_error  = r_external_error;
    assign seq_busy        = r_seq_busy;
    assign done_pulse      = r_done_pulse;
    assign err_pulse       = r_err_pulse;
    assign err_code        = r_err_code;
    assign ops_done        = r_ops_done;

endmodule

// File: doc/axis_splitter_op_sequencer.md
Name: axis_splitter_op_sequencer

Overview:
- Command-driven controller for the multi-channel AXI-Stream packet splitter.
- Accepts descriptors over a valid/ready interface. Each descriptor holds a packet size and an operation count.
- Issues one `operation_start` pulse per operation, then waits for the splitter's complete or error result.
- Enforces a watchdog timeout and handles aborts by driving the splitter's `external_error` input. Reports per-command completion and error status to the host/CSR side.

Parameters:
- PCKT_WIDTH, 32, width of packet size; matches the splitter.
- REP_WIDTH, 16, width of the operation-count field and the progress counter.
- TIMEOUT_WIDTH, 24, width of the watchdog counter.
- TIMEOUT_CYCLES, 0, watchdog limit in cycles per operation; 0 disables the watchdog.
- ABORT_CYCLES, 2, number of cycles `external_error` is held during an abort (minimum 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor ready
- cmd_packet_size  in  PCKT_WIDTH  packet size for all operations of the command
- cmd_count  in  REP_WIDTH  number of operations to run
- abort  in  1  request abort of the running command
- operation_start  out  1  start pulse to the splitter
- packet_size  out  PCKT_WIDTH  registered size to the splitter
- external_error  out  1  error injection to the splitter
- operation_busy  in  1  splitter busy
- operation_complete  in  1  splitter complete
- operation_error  in  1  splitter error
- seq_busy  out  1  high in any state other than IDLE
- done_pulse  out  1  one cycle when a command finishes cleanly
- err_pulse  out  1  one cycle when a command terminates with an error
- err_code  out  2  0 = none, 1 = splitter error, 2 = timeout/abort, 3 = bad command; sticky until next accept
- ops_done  out  REP_WIDTH  operations completed in the current or last command

Behaviour:
- **Reset values:** all outputs are 0; state is IDLE. Reset in any state returns to IDLE within 1 cycle, drops `external_error`, and issues no pulses.
- **Output timing:** all outputs are registered except `cmd_ready`, which equals (state == IDLE).
- **IDLE:**
  - A handshake occurs when `cmd_valid && cmd_ready`.
  - On handshake: latch `packet_size` and `remaining = cmd_count`; clear `ops_done` and `err_code`.
  - If `cmd_count == 0` or `cmd_packet_size == 0`: next cycle `err_pulse = 1`, `err_code = 3`, stay in IDLE, no start issued.
  - Otherwise go to START.
  - `abort` is ignored in IDLE.
- **START:** `operation_start = 1` for exactly this one cycle, then go to RUN. Clear the watchdog counter.
- **RUN:** the watchdog increments each cycle. Events are resolved in priority order abort > error > timeout > complete:
  - `abort` → go to ABORT, `err_code = 2`.
  - `operation_error` → go to IDLE, `err_pulse = 1`, `err_code = 1`.
  - Watchdog reaches `TIMEOUT_CYCLES` (when nonzero) → go to ABORT, `err_code = 2`.
  - `operation_complete` → `ops_done` increments. If `remaining == 1`: `done_pulse = 1`, go to IDLE. Otherwise decrement `remaining` and go to START.
- **Start spacing:** consecutive starts are separated by at least 1 cycle after each complete. The minimum spacing between `operation_start` pulses is 2 cycles.
- **Abort during START:** the start pulse is still issued. The abort is registered, and ABORT is entered the following cycle.
- **ABORT:**
  - `external_error = 1` for ABORT_CYCLES cycles, counted by an internal counter.
  - Then `external_error = 0`, `err_pulse = 1`, go to IDLE.
  - `operation_error` or `operation_complete` during ABORT is ignored.
- **Busy flag:** `seq_busy` is high in START, RUN and ABORT. It is also high in IDLE during the cycle after an accept whose outcome is pending.
- **Pulse exclusivity:** `done_pulse` and `err_pulse` are never high in the same cycle.
- **Output stability:** `packet_size` is stable from accept until the next accept.
- **Counter limits:** `ops_done` saturates at `cmd_count`. The watchdog counter does not wrap; it holds its value once the limit is hit.

Test Plan:
1. **Normal multi-operation command:** `cmd_count = 3`, size 64; splitter completes 5 cycles after each start → exactly 3 `operation_start` pulses, `packet_size = 64`, `ops_done = 3`, one `done_pulse`, `err_code = 0`, `cmd_ready` returns high.
2. **Splitter error:** `operation_error` asserted after start #2 of a 4-operation command → `err_pulse`, `err_code = 1`, `ops_done = 1`, no further starts.
3. **Watchdog timeout:** `TIMEOUT_CYCLES = 10`, splitter never completes → `external_error` high for 2 cycles starting 11 cycles after start, then `err_pulse`, `err_code = 2`.
4. **Abort and priority:** `abort` together with `operation_complete` in RUN → ABORT path wins, `ops_done` unchanged, `external_error` held for 2 cycles. A separate `abort` in IDLE has no effect.
5. **Bad command:** `cmd_count = 0` → `err_pulse` next cycle, `err_code = 3`, no `operation_start`. Likewise `cmd_packet_size = 0` → same response.
6. **Reset mid-operation:** `rst` asserted in RUN and again in ABORT → next cycle all outputs are 0, `cmd_ready = 1`; a new command then runs normally.
